// File: rtl/instr_encoder.sv
// Streaming RV32I instruction encoder: packs immediates into instruction fields and
// stamps sequential addresses into a 2-entry output buffer. Optional macro: IMM_RANGE_CHECK_EN.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        out_err,
  output logic [7:0]  err_cnt
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned ERR_W  = 8;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] addr;
    logic            err;
  } entry_t;

  entry_t             head_q, head_d, tail_q, tail_d, new_e;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [XLEN-1:0]    addr_q, addr_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic [XLEN-1:0]    enc_instr;
  logic               fmt_err, range_err;
  logic               push, pop;

  // Immediate packing into the RV32I field layout for each format
  always_comb begin
    enc_instr = '0;
    fmt_err   = 1'b0;
    case (fmt)
      3'b000, 3'b110: enc_instr = {imm[11:0], rs1, funct3, rd, opcode};
      3'b001:         enc_instr = {imm[31:12], rd, opcode};
      3'b010:         enc_instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      3'b011:         enc_instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      3'b100:         enc_instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      3'b101:         enc_instr = {funct7, imm[4:0], rs1, funct3, rd, opcode};
      default: begin
        enc_instr = NOP;
        fmt_err   = 1'b1;
      end
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // Signed ranges hold when all bits above the field's sign bit match it
  always_comb begin
    range_err = 1'b0;
    case (fmt)
      3'b000, 3'b010: range_err = !((&imm[31:11]) || !(|imm[31:11]));
      3'b001:         range_err = |imm[11:0];
      3'b011:         range_err = imm[0] || !((&imm[31:12]) || !(|imm[31:12]));
      3'b100:         range_err = imm[0] || !((&imm[31:20]) || !(|imm[31:20]));
      3'b101:         range_err = |imm[31:5];
      3'b110:         range_err = |imm[31:12];
      default:        range_err = 1'b0;
    endcase
  end
`else
  assign range_err = 1'b0;
`endif

  assign new_e = '{instr: enc_instr, addr: addr_q, err: fmt_err || range_err};
  assign push  = in_valid && in_ready_q;
  assign pop   = out_valid_q && out_ready;

  // Buffer occupancy, address stamping and error counting
  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    err_cnt_d   = err_cnt_q;
    case (cnt_q)
      2'd0: begin
        if (push) begin
          head_d = new_e;
          cnt_d  = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = new_e;
        end else if (push) begin
          tail_d = new_e;
          cnt_d  = 2'd2;
        end else if (pop) begin
          cnt_d  = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_d = tail_q;
          cnt_d  = 2'd1;
        end
      end
    endcase
    if (push) begin
      addr_d = addr_q + XLEN'(4);
      if (new_e.err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_W'(1);
    end
    in_ready_d  = (cnt_d != 2'd2);
    out_valid_d = (cnt_d != 2'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      addr_q      <= BASE_ADDR;
      err_cnt_q   <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      addr_q      <= addr_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_instr = head_q.instr;
  assign out_addr  = head_q.addr;
  assign out_err   = head_q.err;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed cases then randomized traffic
// against a queue-based reference model.
module tb_instr_encoder;

  localparam logic [31:0] BASE = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  fmt = '0;
  logic [6:0]  opcode = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [31:0] imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr, out_addr;
  logic        out_err;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  instr_encoder #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .out_err(out_err), .err_cnt(err_cnt)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } exp_t;

  int          n_assert = 0;
  int          n_fail = 0;
  exp_t        q[$];
  logic [31:0] m_addr;
  int          m_errs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference encoding built from bit arithmetic on the format rules
  function automatic exp_t model(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                                 input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [31:0] im, input logic [31:0] a);
    exp_t        e;
    logic [31:0] r;
    int          si;
    bit          bad;
    logic [31:0] b_rd, b_f3, b_rs1, b_rs2;
    si    = int'(im);
    b_rd  = 32'(d) << 7;
    b_f3  = 32'(f3) << 12;
    b_rs1 = 32'(s1) << 15;
    b_rs2 = 32'(s2) << 20;
    bad   = 1'b0;
    r     = 32'(op);
    case (f)
      3'd0, 3'd6: begin
        r = r | ((im & 32'hfff) << 20) | b_rs1 | b_f3 | b_rd;
        if (f == 3'd0) bad = (si < -2048) || (si > 2047);
        else           bad = (im > 32'hfff);
      end
      3'd1: begin
        r = r | (im & 32'hffff_f000) | b_rd;
        bad = (im % 4096) != 0;
      end
      3'd2: begin
        r = r | (((im >> 5) & 32'h7f) << 25) | b_rs2 | b_rs1 | b_f3 | ((im & 32'h1f) << 7);
        bad = (si < -2048) || (si > 2047);
      end
      3'd3: begin
        r = r | (((im >> 12) & 1) << 31) | (((im >> 5) & 32'h3f) << 25) | b_rs2 | b_rs1 | b_f3
              | (((im >> 1) & 32'hf) << 8) | (((im >> 11) & 1) << 7);
        bad = (im % 2 != 0) || (si < -4096) || (si > 4094);
      end
      3'd4: begin
        r = r | (((im >> 20) & 1) << 31) | (((im >> 1) & 32'h3ff) << 21) | (((im >> 11) & 1) << 20)
              | (((im >> 12) & 32'hff) << 12) | b_rd;
        bad = (im % 2 != 0) || (si < -(1 << 20)) || (si > (1 << 20) - 2);
      end
      3'd5: begin
        r = r | (32'(f7) << 25) | ((im & 32'h1f) << 20) | b_rs1 | b_f3 | b_rd;
        bad = (im > 32'd31);
      end
      default: r = 32'h0000_0013;
    endcase
`ifdef IMM_RANGE_CHECK_EN
    e.err = (f == 3'd7) || bad;
`else
    e.err = (f == 3'd7);
`endif
    e.instr = r;
    e.addr  = a;
    return e;
  endfunction

  // One clock: check visible state, then advance the model with the edge
  task automatic cycle();
    bit   push, pop;
    exp_t e;
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("head_instr", out_instr, q[0].instr);
      chk("head_addr", out_addr, q[0].addr);
      chk("head_err", 32'(out_err), 32'(q[0].err));
    end
    push = !rst && in_valid && (q.size() < 2);
    pop  = !rst && out_ready && (q.size() > 0);
    e = model(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, m_addr);
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_addr = BASE;
      m_errs = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(e);
        m_addr = m_addr + 32'd4;
        if (e.err && m_errs < 255) m_errs++;
      end
    end
    #1;
    chk("err_cnt", 32'(err_cnt), 32'(m_errs));
  endtask

  task automatic set_in(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] im);
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
  endtask

  // Hold in_valid until the model says the word went in, bounded
  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] im);
    set_in(f, op, d, s1, s2, f3, f7, im);
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      bit acc;
      acc = (q.size() < 2);
      cycle();
      if (acc) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    chk("accept_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic reset_dut();
    in_valid = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] im;
    // Power-on reset, then reset values
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_addr = BASE;
    m_errs = 0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr", out_addr, 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);

    // addi x1, x0, 5 visible the cycle after accept
    out_ready = 1'b1;
    send(3'b000, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_instr", out_instr, 32'h0050_0093);
    chk("t1_addr", out_addr, BASE);
    chk("t1_err", 32'(out_err), 32'd0);
    cycle();

    // lui then sw, sequential addresses
    reset_dut();
    out_ready = 1'b0;
    send(3'b001, 7'b0110111, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    send(3'b010, 7'b0100011, 5'd0, 5'd2, 5'd5, 3'b010, 7'd0, 32'd8);
    chk("t2_instr0", out_instr, 32'h1234_5137);
    chk("t2_addr0", out_addr, BASE);
    out_ready = 1'b1;
    cycle();
    chk("t2_instr1", out_instr, 32'h0051_2423);
    chk("t2_addr1", out_addr, BASE + 32'd4);
    cycle();

    // beq x0, x0, -4
    send(3'b011, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC);
    chk("t3_instr", out_instr, 32'hFE00_0EE3);
    chk("t3_err", 32'(out_err), 32'd0);
    cycle();

    // Out-of-range I immediate, then illegal format
    reset_dut();
    send(3'b000, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096);
`ifdef IMM_RANGE_CHECK_EN
    chk("t4_err", 32'(out_err), 32'd1);
    chk("t4_err_cnt", 32'(err_cnt), 32'd1);
`else
    chk("t4_err", 32'(out_err), 32'd0);
    chk("t4_err_cnt", 32'(err_cnt), 32'd0);
`endif
    cycle();
    send(3'b111, 7'b0110011, 5'd3, 5'd4, 5'd5, 3'd1, 7'd0, 32'd0);
    chk("t4_nop", out_instr, 32'h0000_0013);
    chk("t4_nop_err", 32'(out_err), 32'd1);
    cycle();

    // Backpressure: third input stalls until space frees
    reset_dut();
    out_ready = 1'b0;
    send(3'b000, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    send(3'b000, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
    set_in(3'b000, 7'b0010011, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    in_valid = 1'b1;
    repeat (3) cycle();
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    send(3'b000, 7'b0010011, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    repeat (3) cycle();
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Reset with two words buffered
    out_ready = 1'b0;
    send(3'b001, 7'b0110111, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1000);
    send(3'b111, 7'b0110111, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    reset_dut();
    chk("mr_out_valid", 32'(out_valid), 32'd0);
    chk("mr_out_instr", out_instr, 32'd0);
    chk("mr_err_cnt", 32'(err_cnt), 32'd0);
    send(3'b000, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9);
    chk("mr_addr", out_addr, BASE);
    out_ready = 1'b1;
    cycle();

    // Error counter saturation
    for (int i = 0; i < 260; i++) send(3'b111, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    chk("sat_err_cnt", 32'(err_cnt), 32'd255);
    reset_dut();

    // Randomized traffic with random backpressure
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0:       im = 32'($urandom_range(0, 16383)) - 32'd8192;
        1:       im = $urandom;
        2:       im = $urandom & 32'h3f;
        default: im = $urandom & 32'hffff_f000;
      endcase
      set_in(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
             3'($urandom), 7'($urandom), im);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
